// File: rtl/io_pkg.sv
// Shared IO address map and helpers for the CPU-side IO units.
package io_pkg;

  localparam logic [7:0] ADDR_LED   = 8'h00;
  localparam logic [7:0] ADDR_DISP  = 8'h08;
  localparam logic [7:0] ADDR_READY = 8'h0C;

  // Nibble idx (0..7) of a 32-bit word, least significant nibble first.
  function automatic logic [3:0] nibble_sel(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer with a
// single-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the number of consecutive disagreeing cycles already seen;
  // the DB_CYCLES-th disagreement flips the level instead of counting further.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/io_out_unit.sv
// CPU output IO unit: LED register, acknowledged display register with
// button handshake, and a multiplexed 8-digit hex display scanner.
module io_out_unit
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SCAN_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic [2:0]  an,
  output logic [3:0]  seg,
  output logic [7:0]  led
);

  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [7:0]    led_q, led_d;
  logic [31:0]   disp_q, disp_d;
  logic          ready_q, ready_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    an_q, an_d;
  logic          db_level, db_rise, ack;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (button),
    .level     (db_level),
    .rise_pulse(db_rise)
  );

  assign ack = db_rise & db_level;

  // An accepted display write wins over a same-cycle ack; a dropped one lets the ack through.
  always_comb begin
    led_d   = led_q;
    disp_d  = disp_q;
    ready_d = ready_q;
    if (io_we && io_addr == ADDR_LED) begin
      led_d = io_dout[7:0];
    end
    if (io_we && io_addr == ADDR_DISP && ready_q) begin
      disp_d  = io_dout;
      ready_d = 1'b0;
    end else if (ack) begin
      ready_d = 1'b1;
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    an_d   = an_q;
    if (scan_q == SW'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      an_d   = an_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q   <= '0;
      disp_q  <= '0;
      ready_q <= 1'b1;
      scan_q  <= '0;
      an_q    <= '0;
    end else begin
      led_q   <= led_d;
      disp_q  <= disp_d;
      ready_q <= ready_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
    end
  end

  always_comb begin
    case (io_addr)
      ADDR_LED:   io_din = {24'b0, led_q};
      ADDR_DISP:  io_din = disp_q;
      ADDR_READY: io_din = {31'b0, ready_q};
      default:    io_din = '0;
    endcase
  end

  assign an  = an_q;
  assign seg = nibble_sel(disp_q, an_q);
  assign led = led_q;

endmodule

// File: tb/tb_io_out_unit.sv
// Scoreboard bench for io_out_unit: directed handshake scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_io_out_unit;
  import io_pkg::*;

  localparam int DB = 4;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        button = 1'b0;
  logic        io_we = 1'b0;
  logic [7:0]  io_addr = 8'h00;
  logic [31:0] io_dout = 32'h0;
  logic [31:0] io_din;
  logic [2:0]  an;
  logic [3:0]  seg;
  logic [7:0]  led;

  always #5 clk = ~clk;

  io_out_unit #(
    .DB_CYCLES  (DB),
    .SCAN_CYCLES(SC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .io_we  (io_we),
    .io_addr(io_addr),
    .io_dout(io_dout),
    .io_din (io_din),
    .an     (an),
    .seg    (seg),
    .led    (led)
  );

  typedef struct {
    logic [31:0] din;
    logic [7:0]  led;
    logic [2:0]  an;
    logic [3:0]  seg;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rd_req = 1'b0;

  // Reference model state
  logic [7:0]  m_led = 8'h00;
  logic [31:0] m_disp = 32'h0;
  logic        m_ready = 1'b1;
  logic        m_lvl = 1'b0;
  logic        m_ackp = 1'b0;
  logic        m_valid = 1'b0;
  int          m_cyc = 0;
  logic        m_hist[$];

  // Debounced level flips once the synchronised button (two edges late)
  // has disagreed with it for DB consecutive samples.
  initial begin
    logic all_diff;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_led = 8'h00; m_disp = 32'h0; m_ready = 1'b1;
        m_lvl = 1'b0; m_ackp = 1'b0; m_cyc = 0; m_valid = 1'b1;
        m_hist = {};
        for (int i = 0; i < DB + 2; i++) m_hist.push_front(1'b0);
      end else begin
        if (io_we && io_addr == 8'h00) m_led = io_dout[7:0];
        if (io_we && io_addr == 8'h08 && m_ready) begin
          m_disp = io_dout; m_ready = 1'b0;
        end else if (m_ackp) begin
          m_ready = 1'b1;
        end
        m_cyc++;
        m_hist.push_front(button);
        all_diff = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (m_hist[i] == m_lvl) all_diff = 1'b0;
        m_ackp = 1'b0;
        if (all_diff) begin
          m_lvl  = ~m_lvl;
          m_ackp = m_lvl;
        end
        if (m_hist.size() > DB + 4) void'(m_hist.pop_back());
      end
    end
  end

  function automatic exp_t model_expect(input logic [7:0] a);
    exp_t        e;
    logic [31:0] sh;
    case (a)
      8'h00:   e.din = {24'b0, m_led};
      8'h08:   e.din = m_disp;
      8'h0C:   e.din = {31'b0, m_ready};
      default: e.din = 32'h0;
    endcase
    e.led = m_led;
    e.an  = 3'((m_cyc / SC) % 8);
    sh    = m_disp >> (4 * int'(e.an));
    e.seg = sh[3:0];
    return e;
  endfunction

  task automatic step(input logic r, input logic we, input logic [7:0] a,
                      input logic [31:0] d, input logic b);
    @(negedge clk);
    rst_n = r; io_we = we; io_addr = a; io_dout = d; button = b;
    if (m_valid) begin
      sbq.push_back(model_expect(a));
      rd_req = 1'b1;
    end else begin
      rd_req = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares every presented read against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rd_req) begin
        if (sbq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard_underflow at %0t: got empty expected entry", $time);
        end else begin
          e = sbq.pop_front();
          check($sformatf("io_din[%0h]", io_addr), io_din, e.din);
          check("led", {24'b0, led}, {24'b0, e.led});
          check("an", {29'b0, an}, {29'b0, e.an});
          check("seg", {28'b0, seg}, {28'b0, e.seg});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    int         hold;
    logic       rb;

    // Reset, then idle scan
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ADDR_READY, 32'h0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, ADDR_READY, 32'h0, 1'b0);

    // First display write accepted, then scan through all digits
    step(1'b1, 1'b1, ADDR_DISP, 32'h12345678, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i % 2) ? ADDR_DISP : ADDR_READY, 32'h0, 1'b0);

    // Write while not ready is dropped
    step(1'b1, 1'b1, ADDR_DISP, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, ADDR_DISP, 32'h0, 1'b0);
    step(1'b1, 1'b0, ADDR_READY, 32'h0, 1'b0);

    // Held press: one ack; a write while still held must not be re-acked
    for (int i = 0; i < 14; i++)
      step(1'b1, i == 9, (i == 9) ? ADDR_DISP : ADDR_READY, 32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, ADDR_READY, 32'h0, 1'b0);

    // Short bounce: no ack
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ADDR_READY, 32'h0, (i % 2) == 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, ADDR_READY, 32'h0, 1'b0);

    // Write coinciding with ack, first with ready=0 then with ready=1
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 12; i++)
        step(1'b1, i == 6, (i == 6) ? ADDR_DISP : ADDR_READY, 32'h000000A5, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, (i % 2) ? ADDR_DISP : ADDR_READY, 32'h0, 1'b0);
    end

    // LED write uses the low byte only
    step(1'b1, 1'b1, ADDR_LED, 32'h000001FF, 1'b0);
    step(1'b1, 1'b0, ADDR_LED, 32'h0, 1'b0);

    // Reset in the middle of a debounce while not ready
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADDR_READY, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, ADDR_READY, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, (i % 2) ? ADDR_DISP : ADDR_READY, 32'h0, 1'b0);

    // Randomized traffic
    hold = 0;
    rb   = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        rb   = ~rb;
        hold = $urandom_range(1, 12);
      end
      hold--;
      case ($urandom % 5)
        0:       ra = ADDR_LED;
        1, 2:    ra = ADDR_DISP;
        3:       ra = ADDR_READY;
        default: ra = 8'($urandom);
      endcase
      step(($urandom % 150) != 0, ($urandom % 3) == 0, ra, $urandom, rb);
    end

    @(negedge clk);
    rd_req = 1'b0;
    io_we  = 1'b0;
    @(negedge clk);
    #3;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
